// File: rtl/enc_slice_seq_if.sv
// Handshake bundle between the encoder slice sequencer, the upstream
// hypervector register and the downstream bundler.
interface enc_slice_seq_if #(
  parameter int CTR_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             load_en;
  logic             abort;
  logic [CTR_W-1:0] ctr;
  logic             slice_valid;
  logic             slice_ready;
  logic             first_slice;
  logic             last_slice;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    input  in_valid, abort, slice_ready, done_ready,
    output in_ready, load_en, ctr, slice_valid, first_slice, last_slice,
           done_valid, busy
  );

  modport slave (
    output in_valid, abort, slice_ready, done_ready,
    input  in_ready, load_en, ctr, slice_valid, first_slice, last_slice,
           done_valid, busy
  );
endinterface

// File: rtl/enc_slice_seq.sv
// Slice sequencer for the encoder input mux: walks ctr over the slices of one
// accepted hypervector, then parks ctr on the all-ones code so the mux outputs zeros.

module enc_slice_seq_chk #(
  parameter int NUM_SLICES = 10,
  parameter int CTR_W      = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [CTR_W-1:0] ctr
);
  localparam logic [CTR_W-1:0] PARK_C  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] SLICES_C = CTR_W'(NUM_SLICES);

  a_ctr_legal: assert property (@(posedge clk) disable iff (rst)
    ((ctr < SLICES_C) || (ctr == PARK_C)));
endmodule

module enc_slice_seq #(
  parameter int HV_DIM      = 5000,
  parameter int DIMS_PER_CC = 500,
  parameter int NUM_SLICES  = HV_DIM / DIMS_PER_CC,
  parameter int CTR_W       = 4
) (
  input logic            clk,
  input logic            rst,
  enc_slice_seq_if.master bus
);
  localparam logic [CTR_W-1:0] PARK_C = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] ZERO_C = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] LAST_C = CTR_W'(NUM_SLICES - 1);
  localparam logic [CTR_W-1:0] ONE_C  = CTR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CTR_W-1:0] ctr_r, ctr_s;
  logic             in_ready_r, slice_valid_r, done_valid_r, busy_r;
  logic             load_en_s, beat_s;

  // Next-state and next-select; abort overrides every state.
  always_comb begin
    state_s   = state_r;
    ctr_s     = ctr_r;
    load_en_s = bus.in_valid & in_ready_r & ~bus.abort;
    beat_s    = slice_valid_r & bus.slice_ready;
    if (bus.abort) begin
      state_s = IDLE;
      ctr_s   = PARK_C;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_en_s) begin
            state_s = STREAM;
            ctr_s   = ZERO_C;
          end else begin
            ctr_s = PARK_C;
          end
        end
        STREAM: begin
          if (beat_s && (ctr_r == LAST_C)) begin
            state_s = DONE;
            ctr_s   = PARK_C;
          end else if (beat_s) begin
            ctr_s = ctr_r + ONE_C;
          end else begin
            ctr_s = ctr_r;
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
          ctr_s = PARK_C;
        end
        default: begin
          state_s = IDLE;
          ctr_s   = PARK_C;
        end
      endcase
    end
  end

  // State, select and registered status flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ctr_r         <= PARK_C;
      in_ready_r    <= 1'b1;
      slice_valid_r <= 1'b0;
      done_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      ctr_r         <= ctr_s;
      in_ready_r    <= (state_s == IDLE);
      slice_valid_r <= (state_s == STREAM);
      done_valid_r  <= (state_s == DONE);
      busy_r        <= (state_s != IDLE);
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.load_en     = load_en_s;
  assign bus.ctr         = ctr_r;
  assign bus.slice_valid = slice_valid_r;
  assign bus.first_slice = slice_valid_r & (ctr_r == ZERO_C);
  assign bus.last_slice  = slice_valid_r & (ctr_r == LAST_C);
  assign bus.done_valid  = done_valid_r;
  assign bus.busy        = busy_r;

  enc_slice_seq_chk #(.NUM_SLICES(NUM_SLICES), .CTR_W(CTR_W)) u_chk (
    .clk (clk),
    .rst (rst),
    .ctr (ctr_r)
  );
endmodule

// File: doc/enc_slice_seq.md
Name: enc_slice_seq

Overview:
- Sequencer for the encoder input slice mux.
- Accepts one bundled feature hypervector per transaction from upstream and drives the 4-bit slice select (ctr) through slices 0..NUM_SLICES-1, one DIMS_PER_CC-wide slice per accepted beat.
- Holds ctr on downstream back-pressure, reports transaction completion, and parks the select on an out-of-range code so the mux outputs zeros while idle.

Parameters:
- HV_DIM, 5000, total hypervector dimensions.
- DIMS_PER_CC, 500, dimensions presented per slice beat.
- NUM_SLICES, 10, HV_DIM/DIMS_PER_CC; must be <= 15.
- CTR_W, 4, width of slice select.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream hypervector available.
- in_ready  out  1  sequencer can accept a hypervector.
- load_en  out  1  capture strobe for the upstream hypervector register; equals in_valid & in_ready.
- abort  in  1  synchronous cancel of the current transaction.
- ctr  out  CTR_W  slice select to the mux.
- slice_valid  out  1  current slice on mux output is valid.
- slice_ready  in  1  downstream bundler accepts the slice.
- first_slice  out  1  slice_valid and ctr==0.
- last_slice  out  1  slice_valid and ctr==NUM_SLICES-1.
- done_valid  out  1  transaction completed.
- done_ready  in  1  completion acknowledged.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, STREAM, DONE. Reset enters IDLE asynchronously.
- Reset values:
  - ctr = all-ones (4'hF, park code).
  - slice_valid, done_valid, busy, first_slice, last_slice = 0.
  - in_ready = 1.
- IDLE:
  - in_ready=1, ctr=4'hF.
  - On in_valid: load_en=1 the same cycle; next cycle state=STREAM, ctr=0.
- STREAM:
  - slice_valid=1, in_ready=0.
  - Beat = slice_valid & slice_ready.
  - On a beat with ctr<NUM_SLICES-1: ctr increments next cycle.
  - On a beat with ctr==NUM_SLICES-1: next state=DONE, ctr=4'hF.
  - Without slice_ready: ctr and slice_valid hold indefinitely.
- DONE:
  - done_valid=1, slice_valid=0, in_ready=0.
  - On done_ready: next state=IDLE.
  - in_valid in the same cycle is not accepted; a new transaction starts no earlier than the cycle after IDLE is re-entered.
- Latency:
  - First slice_valid is 1 cycle after load_en.
  - With slice_ready held high: done_valid asserts NUM_SLICES+1 cycles after load_en.
  - Minimum total transaction time: NUM_SLICES+2 cycles including the DONE handshake.
- ctr never takes values in NUM_SLICES..14. Any value other than 0..NUM_SLICES-1 or 4'hF is an assertion failure.
- abort:
  - Highest priority after reset, effective in any state.
  - Next cycle: state=IDLE, ctr=4'hF, slice_valid=0, done_valid=0; no done is produced.
  - A beat coinciding with abort is discarded by downstream; the sequencer does not count it.
  - abort in IDLE with in_valid: abort wins, load_en=0.
- Reset mid-STREAM: immediate return to reset values; no partial done.
- Outputs are registered except load_en, first_slice and last_slice, which are combinational from registered state/ctr and in_valid.

Test Plan:
- Reset then single transaction with slice_ready=1:
  - load_en pulses 1 cycle.
  - ctr steps 0,1,...,9 on consecutive cycles; first_slice at ctr=0, last_slice at ctr=9.
  - done_valid asserts 11 cycles after load_en; done_ready=1 returns to IDLE with ctr=4'hF.
- Back-pressure: slice_ready low for 3 cycles at ctr=4 -> ctr holds 4 and slice_valid stays 1; progression resumes; done is 3 cycles later than the no-stall case.
- Done hold: done_ready low for 5 cycles -> done_valid stays 1, in_ready=0, and a pending in_valid is not accepted until one cycle after done_ready.
- Abort at ctr=6 -> next cycle state IDLE, ctr=4'hF, no done_valid; the next in_valid restarts at ctr=0.
- Async reset asserted mid-cycle at ctr=3 -> outputs take reset values before the next clock edge; ctr=4'hF, busy=0.
- Back-to-back transactions with in_valid held high and done_ready=1 -> load_en pulses every 12 cycles; ctr never leaves {0..9, 4'hF}.
